// File: rtl/slave_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : slave_mem_arbiter_if
// Purpose  : Bundles the two burst-master request channels, the shared
//            read-return path and the SlaveMemCore strobe/address/data lines
//            that connect to slave_mem_arbiter.
// Modports : slave  - the arbiter (consumes requests and MemDataOut, drives
//                     grants, read return and core strobes)
//            master - the environment (bus masters plus the memory core)
// Signals  : req/wr/addr/len/wr_data {0,1}   master request channel
//            gnt/beat_ack/rd_valid {0,1}      per-master response
//            rd_data, busy, err               shared status / read data
//            mem_wen/mem_ren/mem_wr_addr/mem_rd_addr/mem_data_in/mem_data_out
//                                             SlaveMemCore port
// Revision : 1.0 - initial release
// ============================================================================
interface slave_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
);
    // master request channels
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [LEN_W-1:0]  len0;
    logic [LEN_W-1:0]  len1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;

    // per-master responses and shared status
    logic              gnt0;
    logic              gnt1;
    logic              beat_ack0;
    logic              beat_ack1;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid0;
    logic              rd_valid1;
    logic              busy;
    logic              err;

    // memory core side
    logic              mem_wen;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, len0, len1,
               wr_data0, wr_data1, mem_data_out,
        output gnt0, gnt1, beat_ack0, beat_ack1, rd_data, rd_valid0,
               rd_valid1, busy, err, mem_wen, mem_ren, mem_wr_addr,
               mem_rd_addr, mem_data_in
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, len0, len1,
               wr_data0, wr_data1, mem_data_out,
        input  gnt0, gnt1, beat_ack0, beat_ack1, rd_data, rd_valid0,
               rd_valid1, busy, err, mem_wen, mem_ren, mem_wr_addr,
               mem_rd_addr, mem_data_in
    );
endinterface
`default_nettype wire

// File: rtl/slave_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : slave_mem_arbiter
// Purpose  : Two-master round-robin burst arbiter/sequencer in front of the
//            SlaveMemCore array. One burst is in flight at a time; each burst
//            cycle issues exactly one memory beat. Read data is registered and
//            returned one cycle after its beat.
// Ports    : clk  - clock, all state on rising edge
//            rst  - synchronous active-high reset
//            bus  - slave_mem_arbiter_if.slave (masters + memory core)
// Options  : SLAVE_ARB_ERR_EN - when defined, requests whose burst would wrap
//            past the top of the address space are rejected with a one-cycle
//            err pulse instead of being granted.
// Revision : 1.0 - initial release
// ============================================================================
module slave_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    slave_mem_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_ptr;        // master favoured when both request
    logic              r_sel;        // master owning the current burst
    logic              r_wr;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_mem_wen;
    logic              r_mem_ren;
    logic [ADDR_W-1:0] r_mem_wr_addr;
    logic [ADDR_W-1:0] r_mem_rd_addr;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid0;
    logic              r_rd_valid1;
    logic              r_err;

    logic              w_any;
    logic              w_sel;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LEN_W-1:0]  w_sel_len;
    logic              w_reject;
    logic              w_last;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_beat_addr_nxt;

    // ------------------------------------------------------------------
    // Request selection: a lone requester wins outright, a tie goes to
    // the round-robin pointer.
    // ------------------------------------------------------------------
    assign w_any      = bus.req0 | bus.req1;
    assign w_sel      = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
    assign w_sel_wr   = w_sel ? bus.wr1   : bus.wr0;
    assign w_sel_addr = w_sel ? bus.addr1 : bus.addr0;
    assign w_sel_len  = w_sel ? bus.len1  : bus.len0;

`ifdef SLAVE_ARB_ERR_EN
    // Carry out of addr+len means the burst would wrap past the top word.
    logic [ADDR_W:0] w_end;
    assign w_end    = {1'b0, w_sel_addr} + (ADDR_W+1)'(w_sel_len);
    assign w_reject = w_end[ADDR_W];
`else
    assign w_reject = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Beat bookkeeping. The address for the next beat is computed one
    // cycle ahead so the memory strobes and addresses leave registers;
    // the natural ADDR_W truncation gives the wrap to address zero.
    // ------------------------------------------------------------------
    assign w_last          = (r_cnt == r_len);
    assign w_cnt_nxt       = r_cnt + 1'b1;
    assign w_beat_addr_nxt = r_base + ADDR_W'(w_cnt_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= 1'b0;
            r_sel         <= 1'b0;
            r_wr          <= 1'b0;
            r_base        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_mem_wen     <= 1'b0;
            r_mem_ren     <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_rd_addr <= '0;
            r_rd_data     <= '0;
            r_rd_valid0   <= 1'b0;
            r_rd_valid1   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_err       <= 1'b0;
            r_rd_valid0 <= 1'b0;
            r_rd_valid1 <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        if (w_reject) begin
                            // Rejected request still costs the requester
                            // its turn so the other master is not starved.
                            r_err <= 1'b1;
                            r_ptr <= ~w_sel;
                        end else begin
                            r_state   <= S_BURST;
                            r_sel     <= w_sel;
                            r_wr      <= w_sel_wr;
                            r_base    <= w_sel_addr;
                            r_len     <= w_sel_len;
                            r_cnt     <= '0;
                            r_gnt0    <= ~w_sel;
                            r_gnt1    <= w_sel;
                            r_mem_wen <= w_sel_wr;
                            r_mem_ren <= ~w_sel_wr;
                            // Only the address of the active direction
                            // moves; the other one keeps its last value.
                            if (w_sel_wr) begin
                                r_mem_wr_addr <= w_sel_addr;
                            end else begin
                                r_mem_rd_addr <= w_sel_addr;
                            end
                        end
                    end
                end

                S_BURST: begin
                    // Core read is combinational on MemRdAddr, so the beat's
                    // data is present on MemDataOut by the end of the beat.
                    if (!r_wr) begin
                        r_rd_data   <= bus.mem_data_out;
                        r_rd_valid0 <= ~r_sel;
                        r_rd_valid1 <= r_sel;
                    end

                    if (w_last) begin
                        r_state   <= S_IDLE;
                        r_gnt0    <= 1'b0;
                        r_gnt1    <= 1'b0;
                        r_mem_wen <= 1'b0;
                        r_mem_ren <= 1'b0;
                        r_ptr     <= ~r_sel;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (r_wr) begin
                            r_mem_wr_addr <= w_beat_addr_nxt;
                        end else begin
                            r_mem_rd_addr <= w_beat_addr_nxt;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Gnt and BeatAck coincide because every burst cycle is a
    // beat. Write data is steered straight from the owning master so the
    // beat it presents is the beat that is written.
    // ------------------------------------------------------------------
    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.beat_ack0   = r_gnt0;
    assign bus.beat_ack1   = r_gnt1;
    assign bus.rd_data     = r_rd_data;
    assign bus.rd_valid0   = r_rd_valid0;
    assign bus.rd_valid1   = r_rd_valid1;
    assign bus.busy        = (r_state == S_BURST);
    assign bus.err         = r_err;
    assign bus.mem_wen     = r_mem_wen;
    assign bus.mem_ren     = r_mem_ren;
    assign bus.mem_wr_addr = r_mem_wr_addr;
    assign bus.mem_rd_addr = r_mem_rd_addr;
    assign bus.mem_data_in = ((r_state == S_BURST) && r_wr)
                             ? (r_sel ? bus.wr_data1 : bus.wr_data0)
                             : '0;

    a_strobe_exclusive : assert property (@(posedge clk) !(r_mem_wen && r_mem_ren));
    a_grant_exclusive  : assert property (@(posedge clk) !(r_gnt0 && r_gnt1));

endmodule
`default_nettype wire

// File: tb/tb_slave_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_mem_arbiter
// Purpose  : Self-checking bench for slave_mem_arbiter. Provides a 256x32
//            memory core, a table of directed bursts, hand-written
//            round-robin and reset-abort sequences, and randomized bursts
//            checked against a word-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;

`ifdef SLAVE_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slave_mem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    slave_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Memory core: synchronous write, combinational read while ren.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] ref_mem [256];
    logic              init_mem = 1'b1;

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_val(k);
        end else if (bus.mem_wen) begin
            mem[bus.mem_wr_addr] <= bus.mem_data_in;
        end
    end

    assign bus.mem_data_out = bus.mem_ren ? mem[bus.mem_rd_addr] : '0;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ptr  = 0;   // model of round-robin preference

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic gnt(input int m);
        return (m == 1) ? bus.gnt1 : bus.gnt0;
    endfunction
    function automatic logic ack(input int m);
        return (m == 1) ? bus.beat_ack1 : bus.beat_ack0;
    endfunction
    function automatic logic rvalid(input int m);
        return (m == 1) ? bus.rd_valid1 : bus.rd_valid0;
    endfunction

    task automatic drive(input int m, input logic wr, input int a, input int l, input logic [31:0] wd);
        if (m == 1) begin
            bus.wr1 = wr; bus.addr1 = 8'(a); bus.len1 = 4'(l); bus.wr_data1 = wd;
        end else begin
            bus.wr0 = wr; bus.addr0 = 8'(a); bus.len0 = 4'(l); bus.wr_data0 = wd;
        end
    endtask

    task automatic set_req(input int m, input logic v);
        if (m == 1) bus.req1 = v; else bus.req0 = v;
    endtask

    task automatic set_wd(input int m, input logic [31:0] d);
        if (m == 1) bus.wr_data1 = d; else bus.wr_data0 = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 0);
        chk({tag, "_ack"},    {30'd0, bus.beat_ack1, bus.beat_ack0}, 0);
        chk({tag, "_rvalid"}, {30'd0, bus.rd_valid1, bus.rd_valid0}, 0);
        chk({tag, "_rdata"},  bus.rd_data, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_err"},    bus.err, 0);
        chk({tag, "_strobe"}, {30'd0, bus.mem_wen, bus.mem_ren}, 0);
        chk({tag, "_waddr"},  bus.mem_wr_addr, 0);
        chk({tag, "_raddr"},  bus.mem_rd_addr, 0);
        chk({tag, "_din"},    bus.mem_data_in, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    // One complete burst from master m with the FSM idle on entry; beat
    // data is base+i. Req is dropped after beat 'drop' (drop>len: at end).
    task automatic do_burst(input int m, input logic wr, input int addr, input int len,
                            input logic [31:0] base, input int drop, input int exp_last,
                            input logic exp_err);
        int          waited;
        int          o;
        logic [7:0]  ba;
        logic [7:0]  pa;
        logic [31:0] wd;
        o = 1 - m;
        drive(m, wr, addr, len, base);
        set_req(m, 1'b1);
        if (exp_err) begin
            @(posedge clk); #1;
            chk("err_pulse", bus.err, 1);
            chk("err_no_gnt", gnt(m), 0);
            chk("err_idle", bus.busy, 0);
            set_req(m, 1'b0);
            exp_ptr = o;
            @(posedge clk); #1;
            chk("err_one_cycle", bus.err, 0);
            return;
        end
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!gnt(m) && waited < 20);
        chk("gnt_seen", gnt(m), 1);
        if (!gnt(m)) begin
            set_req(m, 1'b0);
            return;
        end
        chk("grant_latency", waited, 1);
        for (int i = 0; i <= len; i++) begin
            wd = base + 32'(i);
            ba = 8'(addr + i);
            set_wd(m, wd);
            #1;
            chk("gnt", gnt(m), 1);
            chk("beat_ack", ack(m), 1);
            chk("other_gnt_ack", {31'd0, gnt(o) | ack(o)}, 0);
            chk("other_rvalid", rvalid(o), 0);
            chk("busy", bus.busy, 1);
            if (wr) begin
                chk("wen", bus.mem_wen, 1);
                chk("ren_off", bus.mem_ren, 0);
                chk("wr_addr", bus.mem_wr_addr, ba);
                chk("data_in", bus.mem_data_in, wd);
                ref_mem[ba] = wd;
            end else begin
                chk("ren", bus.mem_ren, 1);
                chk("wen_off", bus.mem_wen, 0);
                chk("rd_addr", bus.mem_rd_addr, ba);
                chk("rvalid", rvalid(m), (i > 0) ? 1 : 0);
                if (i > 0) begin
                    pa = 8'(addr + i - 1);
                    chk("rd_data", bus.rd_data, ref_mem[pa]);
                end
            end
            if (i == len) chk("last_addr", wr ? bus.mem_wr_addr : bus.mem_rd_addr, exp_last);
            if (i == drop) set_req(m, 1'b0);
            @(posedge clk); #1;
        end
        if (drop > len) set_req(m, 1'b0);
        chk("end_gnt", gnt(m), 0);
        chk("end_ack", ack(m), 0);
        chk("end_busy", bus.busy, 0);
        chk("end_strobes", {30'd0, bus.mem_wen, bus.mem_ren}, 0);
        chk("end_addr_hold", wr ? bus.mem_wr_addr : bus.mem_rd_addr, exp_last);
        chk("end_rvalid", rvalid(m), wr ? 0 : 1);
        if (!wr) begin
            pa = 8'(addr + len);
            chk("end_rd_data", bus.rd_data, ref_mem[pa]);
        end
        exp_ptr = o;
    endtask

    // Both masters request single-beat writes in the same cycle.
    task automatic both_len0(input int a0, input int a1, input logic [31:0] d0, input logic [31:0] d1);
        int          f;
        int          s;
        logic [7:0]  af;
        logic [7:0]  as_;
        logic [31:0] df;
        logic [31:0] ds;
        f   = exp_ptr;
        s   = 1 - f;
        af  = 8'((f == 0) ? a0 : a1);
        as_ = 8'((f == 0) ? a1 : a0);
        df  = (f == 0) ? d0 : d1;
        ds  = (f == 0) ? d1 : d0;
        drive(0, 1'b1, a0, 0, d0);
        drive(1, 1'b1, a1, 0, d1);
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        @(posedge clk); #1;
        chk("rr_first_gnt", gnt(f), 1);
        chk("rr_first_other", gnt(s), 0);
        chk("rr_first_addr", bus.mem_wr_addr, af);
        chk("rr_first_data", bus.mem_data_in, df);
        ref_mem[af] = df;
        set_req(f, 1'b0);
        @(posedge clk); #1;
        chk("rr_gap_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        chk("rr_gap_busy", bus.busy, 0);
        chk("rr_gap_wen", bus.mem_wen, 0);
        @(posedge clk); #1;
        chk("rr_second_gnt", gnt(s), 1);
        chk("rr_second_other", gnt(f), 0);
        chk("rr_second_addr", bus.mem_wr_addr, as_);
        chk("rr_second_data", bus.mem_data_in, ds);
        ref_mem[as_] = ds;
        set_req(s, 1'b0);
        @(posedge clk); #1;
        chk("rr_end_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
        chk("rr_end_busy", bus.busy, 0);
        exp_ptr = f;
    endtask

    typedef struct {
        int   m;
        logic wr;
        int   addr;
        int   len;
        int   base;
        int   drop;
        int   exp_last;
        logic exp_err;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int   ra, rl, rm, rd;
        logic rw;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        for (int k = 0; k < 256; k++) ref_mem[k] = init_val(k);

        tbl[0] = '{0, 1'b1,  22, 3, 100,   0, 25,  1'b0};
        tbl[1] = '{0, 1'b0,  22, 3, 0,     0, 25,  1'b0};
        tbl[2] = '{1, 1'b0, 254, 2, 0,     0, 0,   ERR_EN};
        tbl[3] = '{0, 1'b1, 255, 1, 500,   0, 0,   ERR_EN};
        tbl[4] = '{1, 1'b1,  10, 5, 32'h77, 3, 15, 1'b0};
        tbl[5] = '{1, 1'b0,  10, 5, 0,     6, 15,  1'b0};

        // reset, then five idle cycles
        repeat (3) @(posedge clk);
        #1;
        init_mem = 1'b0;
        rst      = 1'b0;
        exp_ptr  = 0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("idle_busy", bus.busy, 0);
        end
        chk_all_zero("reset");

        for (int t = 0; t < 6; t++) begin
            do_burst(tbl[t].m, tbl[t].wr, tbl[t].addr, tbl[t].len, 32'(tbl[t].base),
                     tbl[t].drop, tbl[t].exp_last, tbl[t].exp_err);
        end

        // round-robin: tie -> pointer, pointer flips after each burst
        do_reset();
        both_len0(60, 61, 32'hAAAA_0060, 32'hBBBB_0061);
        do_burst(0, 1'b1, 70, 0, 32'hCCCC_0070, 0, 70, 1'b0);
        both_len0(62, 63, 32'hAAAA_0062, 32'hBBBB_0063);

        // reset in the middle of an 8-beat write at 40
        do_reset();
        drive(0, 1'b1, 40, 7, 32'hC0DE_0000);
        set_req(0, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            set_wd(0, 32'hC0DE_0000 + 32'(i));
            #1;
            chk("abort_wen", bus.mem_wen, 1);
            chk("abort_addr", bus.mem_wr_addr, 32'(40 + i));
            ref_mem[40 + i] = 32'hC0DE_0000 + 32'(i);
            if (i == 0) set_req(0, 1'b0);
            if (i == 1) rst = 1'b1;
            @(posedge clk); #1;
        end
        chk_all_zero("abort");
        rst     = 1'b0;
        exp_ptr = 0;
        @(posedge clk); #1;
        chk("abort_after_busy", bus.busy, 0);
        chk("abort_after_wen", bus.mem_wen, 0);
        do_burst(0, 1'b0, 40, 7, 0, 0, 47, 1'b0);

        // randomized single-master bursts against the reference memory
        for (int r = 0; r < 24; r++) begin
            rm = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            ra = int'($urandom_range(0, 255));
            rl = int'($urandom_range(0, 15));
            rd = int'($urandom_range(0, rl + 1));
            do_burst(rm, rw, ra, rl, $urandom, rd, (ra + rl) % 256,
                     ERR_EN && (ra + rl > 255));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
